// File: rtl/ds2_c64_joy_mapper_if.sv
// Controller-to-C64 signal bundle: receiver-side levels in, control-port and
// paddle signals out. The mapper sits on the slave side.
interface ds2_c64_joy_mapper_if;
   logic       vsync;
   logic [7:0] stick_lx;
   logic [7:0] stick_ly;
   logic [7:0] stick_rx;
   logic [7:0] stick_ry;
   logic       key_up;
   logic       key_down;
   logic       key_left;
   logic       key_right;
   logic       key_cross;
   logic       key_square;
   logic       key_r1;
   logic       key_select;
   logic [4:0] joy1;
   logic [4:0] joy2;
   logic [7:0] pot_x;
   logic [7:0] pot_y;
   logic       port_sel;
   logic       autofire_en;

   modport master (
      output vsync, stick_lx, stick_ly, stick_rx, stick_ry,
      output key_up, key_down, key_left, key_right,
      output key_cross, key_square, key_r1, key_select,
      input  joy1, joy2, pot_x, pot_y, port_sel, autofire_en
   );

   modport slave (
      input  vsync, stick_lx, stick_ly, stick_rx, stick_ry,
      input  key_up, key_down, key_left, key_right,
      input  key_cross, key_square, key_r1, key_select,
      output joy1, joy2, pot_x, pot_y, port_sel, autofire_en
   );
endinterface

// File: rtl/ds2_c64_joy_mapper.sv
// DualShock2 to C64 control-port mapper. Once per video frame (vsync rising
// edge) the left stick is digitised with hysteresis, merged with the d-pad,
// fire/autofire is resolved, and the result is routed to joy1 or joy2.
// The right stick is passed through as the two paddle bytes.
module ds2_c64_joy_mapper #(
   parameter logic [7:0] DEAD_LO   = 8'd64,
   parameter logic [7:0] DEAD_HI   = 8'd192,
   parameter logic [7:0] HYST      = 8'd16,
   parameter int         AF_FRAMES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   ds2_c64_joy_mapper_if.slave     bus
);

   typedef enum logic [1:0] {
      AX_CENTER = 2'd0,
      AX_NEG    = 2'd1,
      AX_POS    = 2'd2
   } axis_t;

   // Thresholds widened to 9 bits so the hysteresis offsets cannot wrap.
   localparam logic [8:0] LO9     = {1'b0, DEAD_LO};
   localparam logic [8:0] HI9     = {1'b0, DEAD_HI};
   localparam logic [8:0] REL_LO9 = LO9 + {1'b0, HYST};
   localparam logic [8:0] REL_HI9 = HI9 - {1'b0, HYST};
   localparam logic [7:0] AF_LAST = 8'(AF_FRAMES - 1);

   function automatic axis_t axis_next(input axis_t s, input logic [7:0] v);
      logic [8:0] v9;
      axis_t      n;
      v9 = {1'b0, v};
      n  = s;
      case (s)
         AX_CENTER: begin
            if (v9 < LO9)       n = AX_NEG;
            else if (v9 > HI9)  n = AX_POS;
         end
         AX_NEG: begin
            if (v9 > HI9)           n = AX_POS;
            else if (v9 >= REL_LO9) n = AX_CENTER;
         end
         AX_POS: begin
            if (v9 < LO9)           n = AX_NEG;
            else if (v9 <= REL_HI9) n = AX_CENTER;
         end
         default: n = AX_CENTER;
      endcase
      return n;
   endfunction

   axis_t      ax_q, ax_d;
   axis_t      ay_q, ay_d;
   logic       vsync_q;
   logic       r1_prev_q, r1_prev_d;
   logic       sel_prev_q, sel_prev_d;
   logic       af_en_q, af_en_d;
   logic       port_sel_q, port_sel_d;
   logic [7:0] af_cnt_q, af_cnt_d;
   logic       af_phase_q, af_phase_d;
   logic [4:0] joy1_q, joy1_d;
   logic [4:0] joy2_q, joy2_d;
   logic [7:0] pot_x_q, pot_x_d;
   logic [7:0] pot_y_q, pot_y_d;

   logic       tick;
   logic       up, down, left, right;
   logic       af_active, fire;
   logic [4:0] vec;
   axis_t      ax_n, ay_n;
   logic       en_n, sel_n;

   // Frame tick and all next-state/output decisions for that tick.
   always_comb begin
      ax_d        = ax_q;
      ay_d        = ay_q;
      r1_prev_d   = r1_prev_q;
      sel_prev_d  = sel_prev_q;
      af_en_d     = af_en_q;
      port_sel_d  = port_sel_q;
      af_cnt_d    = af_cnt_q;
      af_phase_d  = af_phase_q;
      joy1_d      = joy1_q;
      joy2_d      = joy2_q;
      pot_x_d     = pot_x_q;
      pot_y_d     = pot_y_q;

      tick  = bus.vsync & ~vsync_q;
      ax_n  = axis_next(ax_q, bus.stick_lx);
      ay_n  = axis_next(ay_q, bus.stick_ly);
      en_n  = af_en_q    ^ (bus.key_r1     & ~r1_prev_q);
      sel_n = port_sel_q ^ (bus.key_select & ~sel_prev_q);

      up    = bus.key_up    | (ay_n == AX_NEG);
      down  = bus.key_down  | (ay_n == AX_POS);
      left  = bus.key_left  | (ax_n == AX_NEG);
      right = bus.key_right | (ax_n == AX_POS);

      // Opposing directions cancel rather than pick a winner.
      af_active = en_n & bus.key_square;
      fire      = bus.key_cross | (af_active & af_phase_q);
      vec       = ~{fire, right & ~left, left & ~right, down & ~up, up & ~down};

      if (tick) begin
         ax_d       = ax_n;
         ay_d       = ay_n;
         r1_prev_d  = bus.key_r1;
         sel_prev_d = bus.key_select;
         af_en_d    = en_n;
         port_sel_d = sel_n;
         if (af_active) begin
            if (af_cnt_q == AF_LAST) begin
               af_cnt_d   = 8'd0;
               af_phase_d = ~af_phase_q;
            end else begin
               af_cnt_d   = af_cnt_q + 8'd1;
            end
         end else begin
            af_cnt_d   = 8'd0;
            af_phase_d = 1'b1;
         end
         joy1_d  = sel_n ? vec : 5'h1F;
         joy2_d  = sel_n ? 5'h1F : vec;
         pot_x_d = bus.stick_rx;
         pot_y_d = bus.stick_ry;
      end
   end

   // State and output registers; vsync is sampled every clock for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q    <= 1'b0;
         ax_q       <= AX_CENTER;
         ay_q       <= AX_CENTER;
         r1_prev_q  <= 1'b0;
         sel_prev_q <= 1'b0;
         af_en_q    <= 1'b0;
         port_sel_q <= 1'b0;
         af_cnt_q   <= 8'd0;
         af_phase_q <= 1'b1;
         joy1_q     <= 5'h1F;
         joy2_q     <= 5'h1F;
         pot_x_q    <= 8'h80;
         pot_y_q    <= 8'h80;
      end else begin
         vsync_q    <= bus.vsync;
         ax_q       <= ax_d;
         ay_q       <= ay_d;
         r1_prev_q  <= r1_prev_d;
         sel_prev_q <= sel_prev_d;
         af_en_q    <= af_en_d;
         port_sel_q <= port_sel_d;
         af_cnt_q   <= af_cnt_d;
         af_phase_q <= af_phase_d;
         joy1_q     <= joy1_d;
         joy2_q     <= joy2_d;
         pot_x_q    <= pot_x_d;
         pot_y_q    <= pot_y_d;
      end
   end

   assign bus.joy1        = joy1_q;
   assign bus.joy2        = joy2_q;
   assign bus.pot_x       = pot_x_q;
   assign bus.pot_y       = pot_y_q;
   assign bus.port_sel    = port_sel_q;
   assign bus.autofire_en = af_en_q;

endmodule

// File: tb/tb_ds2_c64_joy_mapper.sv
// Bench for ds2_c64_joy_mapper: directed frames from the test plan plus
// randomised frames, all checked against a frame-level behavioural model.
module tb_ds2_c64_joy_mapper;
   localparam int LO = 64, HI = 192, HY = 16, AF = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ds2_c64_joy_mapper_if bus ();

   ds2_c64_joy_mapper #(
      .DEAD_LO(8'd64), .DEAD_HI(8'd192), .HYST(8'd16), .AF_FRAMES(AF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   // ---------------- behavioural model (one step per frame) ----------------
   int         m_ax = 0, m_ay = 0, m_held = 0;
   bit         m_vprev = 0, m_r1p = 0, m_selp = 0, m_en = 0, m_sel = 0;
   logic [4:0] m_joy1 = 5'h1F, m_joy2 = 5'h1F;
   logic [7:0] m_px = 8'h80, m_py = 8'h80;

   // Direction of a stick axis: -1 negative, 0 centre, +1 positive.
   function automatic int axis_step(input int s, input int v);
      if (s < 0)      return (v > HI) ? 1 : ((v >= LO + HY) ? 0 : -1);
      else if (s > 0) return (v < LO) ? -1 : ((v <= HI - HY) ? 0 : 1);
      else            return (v < LO) ? -1 : ((v > HI) ? 1 : 0);
   endfunction

   always @(posedge clk) begin : model
      int  ax, ay;
      bit  en, sel, u, d, l, r, f, firing;
      logic [4:0] v;
      if (rst) begin
         m_ax <= 0; m_ay <= 0; m_held <= 0;
         m_vprev <= 0; m_r1p <= 0; m_selp <= 0; m_en <= 0; m_sel <= 0;
         m_joy1 <= 5'h1F; m_joy2 <= 5'h1F; m_px <= 8'h80; m_py <= 8'h80;
      end else begin
         m_vprev <= bus.vsync;
         if (bus.vsync && !m_vprev) begin
            ax  = axis_step(m_ax, int'(bus.stick_lx));
            ay  = axis_step(m_ay, int'(bus.stick_ly));
            en  = m_en  ^ (bus.key_r1 && !m_r1p);
            sel = m_sel ^ (bus.key_select && !m_selp);
            u = bus.key_up    || ay < 0;
            d = bus.key_down  || ay > 0;
            l = bus.key_left  || ax < 0;
            r = bus.key_right || ax > 0;
            if (u && d) begin u = 0; d = 0; end
            if (l && r) begin l = 0; r = 0; end
            // Autofire fires for AF frames, rests for AF frames, starting on.
            firing = en && bus.key_square;
            f = bus.key_cross || (firing && ((m_held / AF) % 2 == 0));
            m_held <= firing ? m_held + 1 : 0;
            v = 5'h1F;
            if (f) v[4] = 1'b0;
            if (r) v[3] = 1'b0;
            if (l) v[2] = 1'b0;
            if (d) v[1] = 1'b0;
            if (u) v[0] = 1'b0;
            m_joy1 <= sel ? v : 5'h1F;
            m_joy2 <= sel ? 5'h1F : v;
            m_ax <= ax; m_ay <= ay; m_en <= en; m_sel <= sel;
            m_r1p <= bus.key_r1; m_selp <= bus.key_select;
            m_px <= bus.stick_rx; m_py <= bus.stick_ry;
         end
      end
   end

   // Every cycle: DUT outputs must equal the model.
   always @(negedge clk) begin
      if (chk_on) begin
         n_assert++;
         if (bus.joy1 !== m_joy1 || bus.joy2 !== m_joy2 || bus.pot_x !== m_px ||
             bus.pot_y !== m_py || bus.port_sel !== m_sel || bus.autofire_en !== m_en) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got joy1=%h joy2=%h pot=%h/%h sel=%b af=%b want joy1=%h joy2=%h pot=%h/%h sel=%b af=%b",
                     $time, bus.joy1, bus.joy2, bus.pot_x, bus.pot_y, bus.port_sel, bus.autofire_en,
                     m_joy1, m_joy2, m_px, m_py, m_sel, m_en);
         end
      end
   end

   // Literal check of both DUT and model against a hand-derived value.
   task automatic chk(input string name, input logic [7:0] dut_v, input logic [7:0] mdl_v,
                      input logic [7:0] exp_v);
      n_assert++;
      if (dut_v !== exp_v || mdl_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: dut=%h model=%h required=%h", name, dut_v, mdl_v, exp_v);
      end
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_joy1"}, 8'(bus.joy1), 8'(m_joy1), 8'h1F);
      chk({name, "_joy2"}, 8'(bus.joy2), 8'(m_joy2), 8'h1F);
      chk({name, "_potx"}, bus.pot_x, m_px, 8'h80);
      chk({name, "_poty"}, bus.pot_y, m_py, 8'h80);
      chk({name, "_sel"},  8'(bus.port_sel), 8'(m_sel), 8'h00);
      chk({name, "_af"},   8'(bus.autofire_en), 8'(m_en), 8'h00);
   endtask

   task automatic do_frame();
      @(negedge clk) bus.vsync = 1'b1;
      @(negedge clk);
      @(negedge clk) bus.vsync = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.stick_lx = 8'h80; bus.stick_ly = 8'h80;
      bus.stick_rx = 8'h80; bus.stick_ry = 8'h80;
      bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0;
      bus.key_cross = 0; bus.key_square = 0; bus.key_r1 = 0; bus.key_select = 0;
   endtask

   logic [4:0] af_pat [9] = '{5'h0F, 5'h0F, 5'h0F, 5'h0F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h0F};
   logic [7:0] ly_seq [3] = '{8'h30, 8'h45, 8'h55};
   logic [4:0] ly_exp [3] = '{5'h1E, 5'h1E, 5'h1F};
   logic [7:0] hot    [8] = '{8'h00, 8'h3F, 8'h40, 8'h4F, 8'h50, 8'hB0, 8'hC0, 8'hC1};

   initial begin
      bus.vsync = 1'b0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      chk_reset("reset");
      rst = 1'b0;
      do_frame();
      do_frame();
      chk_reset("idle2");

      // Y-axis hysteresis, then X right.
      for (int i = 0; i < 3; i++) begin
         bus.stick_ly = ly_seq[i];
         do_frame();
         chk($sformatf("ly_hyst%0d", i), 8'(bus.joy2), 8'(m_joy2), 8'(ly_exp[i]));
      end
      bus.stick_ly = 8'h80; bus.stick_lx = 8'hF0; bus.stick_rx = 8'h12; bus.stick_ry = 8'hE7;
      do_frame();
      chk("lx_right", 8'(bus.joy2), 8'(m_joy2), 8'h17);
      chk("potx", bus.pot_x, m_px, 8'h12);
      chk("poty", bus.pot_y, m_py, 8'hE7);
      bus.stick_lx = 8'h80;
      do_frame();

      // Opposing up/down cancel; fire alone.
      bus.key_up = 1; bus.stick_ly = 8'hF0;
      do_frame();
      chk("updown_mask", 8'(bus.joy2), 8'(m_joy2), 8'h1F);
      bus.key_up = 0; bus.stick_ly = 8'h80;
      do_frame();
      bus.key_cross = 1;
      do_frame();
      chk("fire", 8'(bus.joy2), 8'(m_joy2), 8'h0F);
      bus.key_cross = 0;

      // Autofire toggle and pattern.
      bus.key_r1 = 1;
      do_frame();
      chk("af_en", 8'(bus.autofire_en), 8'(m_en), 8'h01);
      bus.key_r1 = 0; bus.key_square = 1;
      for (int i = 0; i < 9; i++) begin
         do_frame();
         chk($sformatf("af_pat%0d", i), 8'(bus.joy2), 8'(m_joy2), 8'(af_pat[i]));
      end
      bus.key_square = 0;
      do_frame();
      chk("af_release", 8'(bus.joy2), 8'(m_joy2), 8'h1F);
      bus.key_square = 1;
      do_frame();
      chk("af_restart", 8'(bus.joy2), 8'(m_joy2), 8'h0F);
      bus.key_square = 0;

      // Port swap with fire held.
      bus.key_cross = 1; bus.key_select = 1;
      do_frame();
      chk("swap_joy1", 8'(bus.joy1), 8'(m_joy1), 8'h0F);
      chk("swap_joy2", 8'(bus.joy2), 8'(m_joy2), 8'h1F);
      chk("swap_sel",  8'(bus.port_sel), 8'(m_sel), 8'h01);
      bus.key_select = 0;
      do_frame();
      chk("swap_hold", 8'(bus.joy1), 8'(m_joy1), 8'h0F);
      bus.key_select = 1;
      do_frame();
      chk("unswap_joy1", 8'(bus.joy1), 8'(m_joy1), 8'h1F);
      chk("unswap_joy2", 8'(bus.joy2), 8'(m_joy2), 8'h0F);
      bus.key_select = 0; bus.key_cross = 0;
      do_frame();

      // Reset mid-autofire with port 1 selected.
      bus.key_select = 1;
      do_frame();
      bus.key_select = 0; bus.key_square = 1;
      do_frame();
      do_frame();
      @(negedge clk) bus.vsync = 1'b1;
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk_reset("midrst");
      bus.vsync = 1'b0; bus.key_square = 0; bus.key_cross = 1;
      @(negedge clk) rst = 1'b0;
      do_frame();
      chk("postrst_joy2", 8'(bus.joy2), 8'(m_joy2), 8'h0F);
      chk("postrst_joy1", 8'(bus.joy1), 8'(m_joy1), 8'h1F);
      bus.key_cross = 0;

      // Randomised frames, including resets released with vsync high.
      for (int f = 0; f < 500; f++) begin
         @(negedge clk);
         bus.stick_lx   = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 7)] : 8'($urandom);
         bus.stick_ly   = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 7)] : 8'($urandom);
         bus.stick_rx   = 8'($urandom);
         bus.stick_ry   = 8'($urandom);
         bus.key_up     = ($urandom_range(0, 5) == 0);
         bus.key_down   = ($urandom_range(0, 5) == 0);
         bus.key_left   = ($urandom_range(0, 5) == 0);
         bus.key_right  = ($urandom_range(0, 5) == 0);
         bus.key_cross  = ($urandom_range(0, 3) == 0);
         bus.key_square = ($urandom_range(0, 3) != 0);
         bus.key_r1     = ($urandom_range(0, 4) == 0);
         bus.key_select = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            bus.vsync = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst = 1'b0;
         end
         bus.vsync = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         bus.vsync = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
